// File: rtl/bday_pkg.sv
// Shared definitions for the birthday digit display: FSM states,
// active-low seven-segment patterns and the digit code width.
package bday_pkg;

    localparam int DIGIT_W = 4;
    localparam int SLOTS   = 4;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        SHOWING = 2'd2
    } state_t;

    // Active-low patterns ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// Combinational digit-code to active-low seven-segment decoder.
// Codes above 9 render as a dash so bad upstream data is visible.
module seg7_decode
    import bday_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_code,
    output logic [6:0]         o_seg
);

    always_comb begin
        o_seg = SEG_DASH;
        case (i_code)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bday_display.sv
// Four-digit multiplexed display for the birthday sequence: captures digits
// into a shift buffer and scans the filled slots onto the anodes.
module bday_display
    import bday_pkg::*;
#(
    parameter int REFRESH_DIV = 1000
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               digit_valid,
    input  logic               hold,
    output logic [6:0]         seg,
    output logic [3:0]         an,
    output logic               full
);

    localparam int SCAN_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [DIGIT_W-1:0] r_buf [SLOTS];
    logic [DIGIT_W-1:0] w_buf_next [SLOTS];
    logic [2:0]         r_cnt;
    logic [2:0]         w_cnt_next;
    logic [SCAN_W-1:0]  r_scan;
    logic [SCAN_W-1:0]  w_scan_next;
    logic [1:0]         r_slot;
    logic [1:0]         w_slot_next;
    logic               w_capture;

    logic [6:0]         r_seg;
    logic [3:0]         r_an;
    logic               r_full;
    logic [6:0]         w_seg_next;
    logic [3:0]         w_an_next;
    logic               w_full_next;
    logic [DIGIT_W-1:0] w_dec_code;
    logic [6:0]         w_dec_seg;

    assign w_capture = digit_valid && !hold;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_scan_next  = r_scan + 1'b1;
        w_slot_next  = r_slot;
        for (int i = 0; i < SLOTS; i++) begin
            w_buf_next[i] = r_buf[i];
        end

        if (w_capture) begin
            w_buf_next[0] = digit;
            for (int i = 1; i < SLOTS; i++) begin
                w_buf_next[i] = r_buf[i-1];
            end
            if (r_cnt != 3'd4) begin
                w_cnt_next = r_cnt + 3'd1;
            end
        end

        if (r_scan == SCAN_LAST) begin
            w_scan_next = '0;
            w_slot_next = r_slot + 2'd1;
        end

        case (r_state)
            EMPTY:   if (w_capture) w_state_next = FILLING;
            FILLING: if (w_capture && r_cnt == 3'd3) w_state_next = SHOWING;
            SHOWING: w_state_next = SHOWING;
            default: w_state_next = EMPTY;
        endcase
    end

    // Outputs are built from next-state values so a shift and a slot advance
    // on the same edge are shown together, with seg and an in lockstep.
    assign w_dec_code = w_buf_next[w_slot_next];

    seg7_decode u_decode (
        .i_code (w_dec_code),
        .o_seg  (w_dec_seg)
    );

    always_comb begin
        w_an_next   = 4'b1111;
        w_seg_next  = SEG_BLANK;
        w_full_next = (w_state_next == SHOWING);
        if ({1'b0, w_slot_next} < w_cnt_next) begin
            w_an_next[w_slot_next] = 1'b0;
            w_seg_next             = w_dec_seg;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
            r_cnt   <= '0;
            r_scan  <= '0;
            r_slot  <= '0;
            r_seg   <= SEG_BLANK;
            r_an    <= 4'b1111;
            r_full  <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_scan  <= w_scan_next;
            r_slot  <= w_slot_next;
            r_seg   <= w_seg_next;
            r_an    <= w_an_next;
            r_full  <= w_full_next;
            for (int i = 0; i < SLOTS; i++) begin
                r_buf[i] <= w_buf_next[i];
            end
        end
    end

    assign seg  = r_seg;
    assign an   = r_an;
    assign full = r_full;

endmodule

// File: tb/tb_bday_display.sv
// Scoreboard bench for bday_display: a cycle model pushes expected outputs on
// each rising edge and a checker pops and compares them on the falling edge.
module tb_bday_display;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] digit = 4'd0;
    logic       digit_valid = 1'b0;
    logic       hold = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       full;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       full;
    } exp_t;

    exp_t       sbq[$];
    int         n_compared = 0;
    int         n_mismatched = 0;
    logic [3:0] m_buf [4];
    int         m_cnt = 0;
    int         m_scan = 0;
    int         m_slot = 0;

    bday_display #(.REFRESH_DIV(DIV)) dut (
        .clk         (clk),
        .reset       (reset),
        .digit       (digit),
        .digit_valid (digit_valid),
        .hold        (hold),
        .seg         (seg),
        .an          (an),
        .full        (full)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] exp_seg(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;
            4'd1: return 7'h79;
            4'd2: return 7'h24;
            4'd3: return 7'h30;
            4'd4: return 7'h19;
            4'd5: return 7'h12;
            4'd6: return 7'h02;
            4'd7: return 7'h78;
            4'd8: return 7'h00;
            4'd9: return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    // Reference model: advances on every rising edge and records the expected outputs
    always @(posedge clk or posedge reset) begin
        exp_t e;
        if (reset) begin
            for (int i = 0; i < 4; i++) m_buf[i] = 4'd0;
            m_cnt  = 0;
            m_scan = 0;
            m_slot = 0;
            sbq.delete();
        end else begin
            if (digit_valid && !hold) begin
                for (int i = 3; i > 0; i--) m_buf[i] = m_buf[i-1];
                m_buf[0] = digit;
                if (m_cnt < 4) m_cnt = m_cnt + 1;
            end
            if (m_scan == DIV - 1) begin
                m_scan = 0;
                m_slot = (m_slot + 1) % 4;
            end else begin
                m_scan = m_scan + 1;
            end
            e.an   = 4'b1111;
            e.seg  = 7'h7F;
            e.full = (m_cnt == 4);
            if (m_slot < m_cnt) begin
                e.an[m_slot] = 1'b0;
                e.seg        = exp_seg(m_buf[m_slot]);
            end
            sbq.push_back(e);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            n_compared += 3;
            if (an !== 4'b1111) begin
                n_mismatched++;
                $display("[TB] FAIL reset_an: got %b want 1111", an);
            end
            if (seg !== 7'h7F) begin
                n_mismatched++;
                $display("[TB] FAIL reset_seg: got %h want 7f", seg);
            end
            if (full !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_full: got %b want 0", full);
            end
        end else if (sbq.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL scoreboard_underflow: got empty queue want entry");
        end else begin
            e = sbq.pop_front();
            n_compared += 3;
            if (an !== e.an) begin
                n_mismatched++;
                $display("[TB] FAIL sb_an at %0t: got %b want %b", $time, an, e.an);
            end
            if (seg !== e.seg) begin
                n_mismatched++;
                $display("[TB] FAIL sb_seg at %0t: got %h want %h", $time, seg, e.seg);
            end
            if (full !== e.full) begin
                n_mismatched++;
                $display("[TB] FAIL sb_full at %0t: got %b want %b", $time, full, e.full);
            end
        end
    end

    task automatic applyReset();
        @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic capture(input logic [3:0] d);
        @(negedge clk);
        digit       = d;
        digit_valid = 1'b1;
        @(negedge clk);
        digit_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        n_compared++;
        if (an !== 4'b1111 || full !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL idle_after_reset: got an=%b full=%b want an=1111 full=0", an, full);
        end
    endtask

    task automatic test_two_digits();
        logic       upper_lit = 1'b0;
        logic [6:0] s0 = 7'h7F;
        logic [6:0] s1 = 7'h7F;
        applyReset();
        capture(4'd2);
        capture(4'd1);
        for (int k = 0; k < 8 * DIV; k++) begin
            @(negedge clk);
            if (an[2] === 1'b0 || an[3] === 1'b0) upper_lit = 1'b1;
            if (an === 4'b1110) s0 = seg;
            if (an === 4'b1101) s1 = seg;
        end
        n_compared += 4;
        if (upper_lit !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL two_upper_unlit: got lit=1 want lit=0");
        end
        if (s0 !== 7'h79) begin
            n_mismatched++;
            $display("[TB] FAIL two_slot0: got %h want 79", s0);
        end
        if (s1 !== 7'h24) begin
            n_mismatched++;
            $display("[TB] FAIL two_slot1: got %h want 24", s1);
        end
        if (full !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL two_full: got %b want 0", full);
        end
    endtask

    task automatic test_fill();
        logic [6:0] s [4];
        logic [6:0] want [4];
        want[0] = 7'h12; want[1] = 7'h19; want[2] = 7'h30; want[3] = 7'h24;
        for (int i = 0; i < 4; i++) s[i] = 7'h7F;
        applyReset();
        capture(4'd1);
        capture(4'd2);
        capture(4'd3);
        n_compared++;
        if (full !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL fill_full_after3: got %b want 0", full);
        end
        capture(4'd4);
        n_compared++;
        if (full !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL fill_full_after4: got %b want 1", full);
        end
        capture(4'd5);
        for (int k = 0; k < 8 * DIV; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (an[i] === 1'b0) s[i] = seg;
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_compared++;
            if (s[i] !== want[i]) begin
                n_mismatched++;
                $display("[TB] FAIL fill_slot%0d: got %h want %h", i, s[i], want[i]);
            end
        end
    endtask

    task automatic test_hold();
        @(negedge clk);
        hold        = 1'b1;
        digit       = 4'd9;
        digit_valid = 1'b1;
        repeat (6 * DIV) @(negedge clk);
        digit_valid = 1'b0;
        for (int k = 0; k < 8 * DIV && an !== 4'b1110; k++) @(negedge clk);
        n_compared++;
        if (an !== 4'b1110 || seg !== 7'h12) begin
            n_mismatched++;
            $display("[TB] FAIL hold_slot0: got an=%b seg=%h want an=1110 seg=12", an, seg);
        end
        hold = 1'b0;
        capture(4'd9);
        for (int k = 0; k < 8 * DIV && an !== 4'b1110; k++) @(negedge clk);
        n_compared++;
        if (an !== 4'b1110 || seg !== 7'h10) begin
            n_mismatched++;
            $display("[TB] FAIL release_slot0: got an=%b seg=%h want an=1110 seg=10", an, seg);
        end
    endtask

    task automatic test_dash();
        applyReset();
        capture(4'd12);
        for (int k = 0; k < 8 * DIV && an !== 4'b1110; k++) @(negedge clk);
        n_compared++;
        if (an !== 4'b1110 || seg !== 7'h3F) begin
            n_mismatched++;
            $display("[TB] FAIL dash_slot0: got an=%b seg=%h want an=1110 seg=3f", an, seg);
        end
    endtask

    task automatic test_async_reset();
        applyReset();
        for (int i = 0; i < 4; i++) capture(4'(i + 6));
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        n_compared += 3;
        if (an !== 4'b1111) begin
            n_mismatched++;
            $display("[TB] FAIL async_an: got %b want 1111", an);
        end
        if (full !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL async_full: got %b want 0", full);
        end
        if (seg !== 7'h7F) begin
            n_mismatched++;
            $display("[TB] FAIL async_seg: got %h want 7f", seg);
        end
        @(negedge clk);
        #2 reset = 1'b0;
        capture(4'd7);
        n_compared++;
        if (full !== 1'b0 || an[3:1] !== 3'b111) begin
            n_mismatched++;
            $display("[TB] FAIL restart_filling: got an=%b full=%b want an=111x full=0", an, full);
        end
        for (int k = 0; k < 8 * DIV && an !== 4'b1110; k++) @(negedge clk);
        n_compared++;
        if (an !== 4'b1110 || seg !== 7'h78) begin
            n_mismatched++;
            $display("[TB] FAIL restart_slot0: got an=%b seg=%h want an=1110 seg=78", an, seg);
        end
    endtask

    // Captures on consecutive cycles, crossing scan wraps, with random holds
    task automatic test_back_to_back();
        applyReset();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            digit       = 4'($urandom_range(0, 15));
            digit_valid = 1'b1;
            hold        = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        digit_valid = 1'b0;
        hold        = 1'b0;
        repeat (8 * DIV) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_two_digits();
        test_fill();
        test_hold();
        test_dash();
        test_async_reset();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/bday_display.md
BDAY_DISPLAY -- requirements
Module: bday_display

Interface
REQ-001 Parameter REFRESH_DIV, default 1000, clock cycles each digit slot is driven before the scan advances (legal range 2 to 2^16).
REQ-002 Port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1, asynchronous active-high reset.
REQ-004 Port digit, input, 4, digit code from the upstream birthday sequence counter (its birth output).
REQ-005 Port digit_valid, input, 1, strobe: capture digit this cycle.
REQ-006 Port hold, input, 1, freeze the digit buffer while high.
REQ-007 Port seg, output, 7, active-low segments {g,f,e,d,c,b,a}.
REQ-008 Port an, output, 4, active-low anodes; an[0] is the rightmost display position.
REQ-009 Port full, output, 1, high when all four slots hold captured digits.

Function
REQ-010 Buffer: 4 x 4-bit shift register buf[0..3]; on capture, buf[0] <= digit and buf[i] <= buf[i-1], so buf[3] drops the oldest digit.
REQ-011 Capture occurs when digit_valid=1 and hold=0; while hold=1, digit_valid is ignored and the buffer and fill count are unchanged.
REQ-012 Fill count cnt (0..4): increments on each capture and saturates at 4.
REQ-013 FSM states: EMPTY (cnt=0), FILLING (cnt 1..3), SHOWING (cnt=4).
REQ-014 FSM transitions: EMPTY->FILLING on the first capture; FILLING->SHOWING on the capture that makes cnt=4; SHOWING remains until reset.
REQ-015 Scan counter: counts 0..REFRESH_DIV-1 and wraps; slot (2 bits) increments modulo 4 on each wrap; it runs in every state.
REQ-016 Anode drive: an[slot]=0 only when slot < cnt; all other anode bits are 1; in EMPTY, an = 4'b1111.
REQ-017 seg shows the decode of buf[slot], registered, so seg and an change on the same clock edge.
REQ-018 Decode values: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
REQ-019 Codes 10..15 decode to a dash (0x3F).
REQ-020 Any unlit slot drives seg=0x7F.
REQ-021 full = (state == SHOWING), registered.
REQ-022 Capture latency: a captured digit appears in buf[0] on the next edge; it is visible on seg the first time slot 0 is scanned after that edge.
REQ-023 Capture and scan wrap in the same cycle: the buffer shift and the slot advance both take effect; seg for the new slot reflects the post-shift buffer.

Reset
REQ-024 When reset is asserted, at any time, all storage clears immediately: buf=0, cnt=0, state=EMPTY, scan counter=0, slot=0.
REQ-025 During and after reset, until the first capture: an=4'b1111, seg=0x7F, full=0.
REQ-026 Reset deassertion is synchronous to clk; the first capture is accepted on the first rising edge with reset=0.

Structure
REQ-027 Shared package bday_pkg holds the state enum (EMPTY, FILLING, SHOWING), the segment constants (SEG_0..SEG_9, SEG_DASH=0x3F, SEG_BLANK=0x7F) and the digit width constant 4.
REQ-028 One combinational sub-module, seg7_decode (4-bit code in, 7-bit active-low pattern out), is instantiated once.
REQ-029 The FSM, buffer and scan logic live in bday_display.

Verification
REQ-030 Reset, then no valid -> an=1111, seg=0x7F, full=0 for 4*REFRESH_DIV cycles.
REQ-031 REFRESH_DIV=4; capture 2, then 1 -> only an[0] and an[1] ever go low; slot0 seg=0x79, slot1 seg=0x24; full=0.
REQ-032 Capture 1,2,3,4,5 -> full=1 after the 4th capture; slots 0..3 show 5,4,3,2 (0x12, 0x19, 0x30, 0x24).
REQ-033 hold=1 with digit_valid pulses of 9 -> buffer and cnt unchanged; releasing hold and capturing 9 -> slot0 shows 0x10.
REQ-034 Capture code 12 -> its slot shows 0x3F.
REQ-035 Assert reset asynchronously mid-cycle while SHOWING -> an=1111 and full=0 before the next clk edge; the next capture restarts from FILLING.
